// File: rtl/wave_pipe_ctrl_pkg.sv
// rtl/wave_pipe_ctrl_pkg.sv - shared types and constants for the wave_former control blocks
package wave_former_pkg;

    typedef enum logic {PRIME, RUN} wave_ctrl_state_t;

    localparam int STATS_W = 32;

endpackage

// File: rtl/wave_pipe_ctrl_if.sv
// rtl/wave_pipe_ctrl_if.sv - upstream/downstream valid-ready handshake bundle of the pipe controller
interface wave_pipe_ctrl_if;

    logic s_valid;
    logic s_ready;
    logic m_valid;
    logic m_ready;

    // Controller side: accepts upstream samples, presents downstream results.
    modport master (
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_valid
    );

    // Environment side: produces upstream samples, consumes downstream results.
    modport slave (
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_valid
    );

endinterface

// File: rtl/wave_pipe_ctrl_vld.sv
// rtl/wave_pipe_ctrl_vld.sv - wave_vld_pipe, enable-gated per-stage valid shift register
module wave_vld_pipe #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic enable_i,
    input  logic vld_i,
    output logic vld_o
);

    logic [STAGES-1:0] vld_sr_q;
    logic [STAGES-1:0] vld_sr_d;

    // Shifted image of the valid chain; written as a loop so STAGES==1 needs no special case.
    always_comb begin
        vld_sr_d    = vld_sr_q;
        vld_sr_d[0] = vld_i;
        for (int i = 1; i < STAGES; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    // Valid bits move only with the datapath enable, so bubbles travel with the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_sr_q <= '0;
        end else if (flush_i) begin
            vld_sr_q <= '0;
        end else if (enable_i) begin
            vld_sr_q <= vld_sr_d;
        end
    end

    assign vld_o = vld_sr_q[STAGES-1];

endmodule

// File: rtl/wave_pipe_ctrl.sv
// rtl/wave_pipe_ctrl.sv - handshake/enable controller for the wave_former delay line and pipeline (optional WAVE_PIPE_CTRL_STATS_EN)
module wave_pipe_ctrl
    import wave_former_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int DELAY_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    wave_pipe_ctrl_if.master     bus,
    output logic                 enable,
    output logic                 delay_en,
    output logic                 primed
`ifdef WAVE_PIPE_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]   stall_cnt,
    output logic [STATS_W-1:0]   out_cnt
`endif
);

    // A zero-depth delay line still needs a one-bit counter to keep the declarations legal.
    localparam int CNT_W = (DELAY_DEPTH > 0) ? $clog2(DELAY_DEPTH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DELAY_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DELAY_DEPTH > 0) ? DELAY_DEPTH - 1 : 0);
    localparam wave_ctrl_state_t RST_STATE = (DELAY_DEPTH == 0) ? RUN : PRIME;

    wave_ctrl_state_t  state_q;
    logic [CNT_W-1:0]  prime_cnt_q;
    logic              primed_q;

    logic m_valid_w;
    logic out_free;
    logic s_ready_w;
    logic accept;
    logic vld_in;

    // The whole pipeline advances unless the output slot holds an unaccepted sample;
    // a flush forces one enabled cycle so the cleared valids take effect everywhere.
    assign out_free  = !m_valid_w || bus.m_ready;
    assign enable    = out_free || flush;
    assign s_ready_w = out_free && !flush;
    assign accept    = bus.s_valid && s_ready_w;
    assign delay_en  = accept;

    // Priming samples fill the delay line but never reach the output.
    assign vld_in    = accept && (state_q == RUN);

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_w;
    assign primed      = primed_q;

    wave_vld_pipe #(
        .STAGES (STAGES)
    ) u_vld_pipe (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (flush),
        .enable_i (enable),
        .vld_i    (vld_in),
        .vld_o    (m_valid_w)
    );

    // PRIME/RUN sequencer: counts priming accepts, enters RUN on the last one, holds RUN until flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            prime_cnt_q <= '0;
            primed_q    <= (RST_STATE == RUN);
        end else if (flush) begin
            state_q     <= RST_STATE;
            prime_cnt_q <= '0;
            primed_q    <= (RST_STATE == RUN);
        end else if (accept && (state_q == PRIME)) begin
            if (prime_cnt_q != CNT_MAX) begin
                prime_cnt_q <= prime_cnt_q + CNT_W'(1);
            end
            if (prime_cnt_q == CNT_LAST) begin
                state_q  <= RUN;
                primed_q <= 1'b1;
            end
        end
    end

`ifdef WAVE_PIPE_CTRL_STATS_EN
    logic [STATS_W-1:0] stall_cnt_q;
    logic [STATS_W-1:0] out_cnt_q;

    // Free-running (wrapping) counters of output stalls and completed output transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            out_cnt_q   <= '0;
        end else if (flush) begin
            stall_cnt_q <= '0;
            out_cnt_q   <= '0;
        end else begin
            if (m_valid_w && !bus.m_ready) begin
                stall_cnt_q <= stall_cnt_q + STATS_W'(1);
            end
            if (m_valid_w && bus.m_ready) begin
                out_cnt_q <= out_cnt_q + STATS_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign out_cnt   = out_cnt_q;
`endif

endmodule
